branch_resolve_stage: RTL and testbench

Execute-to-memory stage of the RV32I pipeline, directly downstream of the ALU. It consumes the ALU result and comparison flags (EQ, LU, LS), resolves conditional branches and jumps, and produces a one-cycle fetch redirect. It registers the surviving instruction into a 2-entry elastic EX/MEM buffer with valid/ready handshakes on both sides. It also discards the single wrong-path instruction that follows a taken control transfer.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/branch_cond.sv | 27 ++
 rtl/branch_resolve_stage.sv | 153 +++++++++++++++
 tb/tb_branch_resolve_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: op classes, branch funct3 codes and the EX/MEM payload.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 3;
    localparam int unsigned F3_W = 3;
    localparam int unsigned RD_W = 5;

    localparam logic [OP_W-1:0] OP_ALU    = 3'd0;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd1;
    localparam logic [OP_W-1:0] OP_JAL    = 3'd2;
    localparam logic [OP_W-1:0] OP_JALR   = 3'd3;
    localparam logic [OP_W-1:0] OP_LOAD   = 3'd4;
    localparam logic [OP_W-1:0] OP_STORE  = 3'd5;

    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    localparam int unsigned EXMEM_W = OP_W + F3_W + RD_W + XLEN + XLEN + 1;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [F3_W-1:0] funct3;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic            trap;
    } exmem_t;

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch decision from funct3 and the ALU comparison flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [F3_W-1:0] funct3_i,
    input  logic            eq_i,
    input  logic            lu_i,
    input  logic            ls_i,
    output logic            taken_c,
    output logic            illegal_c
);

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_c = eq_i;
            F3_BNE:  taken_c = !eq_i;
            F3_BLT:  taken_c = ls_i;
            F3_BGE:  taken_c = !ls_i;
            F3_BLTU: taken_c = lu_i;
            F3_BGEU: taken_c = !lu_i;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_stage.sv
// EX/MEM stage: resolves branches/jumps, issues a one-cycle redirect, drops the wrong-path beat
// and holds surviving beats in a 2-entry elastic buffer.
module branch_resolve_stage
    import cpu_pkg::*;
#(
    parameter bit RESET_PC_LSB_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [OP_W-1:0] in_op,
    input  logic [F3_W-1:0] in_funct3,
    input  logic [RD_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_alu_s,
    input  logic            in_eq,
    input  logic            in_lu,
    input  logic            in_ls,
    input  logic [XLEN-1:0] in_store_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [F3_W-1:0] out_funct3,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_trap,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    exmem_t          main_q, main_d, skid_q, skid_d, beat_c;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            kill_q, kill_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    logic            cond_taken_c, cond_illegal_c;
    logic            is_branch_c, is_jal_c, is_jalr_c;
    logic [XLEN-1:0] target_c, pc_plus4_c;
    logic            taken_c, misalign_c;
    logic            accept_c, drain_c, write_c, redirect_c;

    branch_cond u_branch_cond (
        .funct3_i  (in_funct3),
        .eq_i      (in_eq),
        .lu_i      (in_lu),
        .ls_i      (in_ls),
        .taken_c   (cond_taken_c),
        .illegal_c (cond_illegal_c)
    );

    // Resolve the incoming beat and build its EX/MEM payload
    always_comb begin
        is_branch_c = (in_op == OP_BRANCH);
        is_jal_c    = (in_op == OP_JAL);
        is_jalr_c   = (in_op == OP_JALR);
        target_c    = is_jalr_c ? (in_alu_s & ~XLEN'(1)) : (in_pc + in_imm);
        pc_plus4_c  = in_pc + XLEN'(4);
        taken_c     = (is_branch_c && cond_taken_c) || is_jal_c || is_jalr_c;
        misalign_c  = RESET_PC_LSB_CHECK && taken_c && (target_c[1:0] != 2'b00);

        beat_c            = '0;
        beat_c.op         = in_op;
        beat_c.funct3     = in_funct3;
        beat_c.rd         = (is_branch_c || misalign_c) ? '0 : in_rd;
        beat_c.store_data = in_store_data;
        beat_c.trap       = (is_branch_c && cond_illegal_c) || misalign_c;
        if (is_jal_c || is_jalr_c) begin
            beat_c.result = pc_plus4_c;
        end else if (is_branch_c) begin
            beat_c.result = '0;
        end else begin
            beat_c.result = in_alu_s;
        end
    end

    assign accept_c   = in_valid && in_ready;
    assign drain_c    = main_valid_q && out_ready;
    assign write_c    = accept_c && !kill_q;
    assign redirect_c = write_c && taken_c && !misalign_c;

    // Next-state: kill flag, redirect pulse and FIFO-ordered main/skid buffer
    always_comb begin
        main_d        = main_q;
        main_valid_d  = main_valid_q;
        skid_d        = skid_q;
        skid_valid_d  = skid_valid_q;
        kill_d        = kill_q;
        redir_valid_d = redirect_c;
        redir_pc_d    = redirect_c ? target_c : redir_pc_q;

        if (accept_c && kill_q) begin
            kill_d = 1'b0;
        end else if (redirect_c) begin
            kill_d = 1'b1;
        end

        if (drain_c) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (write_c) begin
                main_d = beat_c;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (write_c) begin
            if (!main_valid_q) begin
                main_d       = beat_c;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = beat_c;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q        <= '0;
            main_valid_q  <= 1'b0;
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
            kill_q        <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            main_q        <= main_d;
            main_valid_q  <= main_valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
            kill_q        <= kill_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign in_ready       = !skid_valid_q;
    assign out_valid      = main_valid_q;
    assign out_op         = main_q.op;
    assign out_funct3     = main_q.funct3;
    assign out_rd         = main_q.rd;
    assign out_result     = main_q.result;
    assign out_store_data = main_q.store_data;
    assign out_trap       = main_q.trap;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_branch_resolve_stage.sv
// Directed + randomized bench for branch_resolve_stage against an operand-level reference model.
module tb_branch_resolve_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_imm, in_alu_s, in_store_data;
    logic [2:0]  in_op, in_funct3;
    logic [4:0]  in_rd;
    logic        in_eq, in_lu, in_ls;
    logic        out_valid, out_ready;
    logic [2:0]  out_op, out_funct3;
    logic [4:0]  out_rd;
    logic [31:0] out_result, out_store_data;
    logic        out_trap;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] opa, opb;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] sd;
        logic        trap;
    } item_t;

    item_t       mq[$];
    bit          m_kill;
    bit          m_rv;
    logic [31:0] m_rpc;

    int checks   = 0;
    int failures = 0;

    branch_resolve_stage #(.RESET_PC_LSB_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_imm(in_imm), .in_op(in_op), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_alu_s(in_alu_s),
        .in_eq(in_eq), .in_lu(in_lu), .in_ls(in_ls),
        .in_store_data(in_store_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_funct3(out_funct3), .out_rd(out_rd),
        .out_result(out_result), .out_store_data(out_store_data), .out_trap(out_trap),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_op", 32'(out_op), 32'(mq[0].op));
            chk("out_funct3", 32'(out_funct3), 32'(mq[0].f3));
            chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
            chk("out_result", out_result, mq[0].res);
            chk("out_store_data", out_store_data, mq[0].sd);
            chk("out_trap", 32'(out_trap), 32'(mq[0].trap));
        end
        chk("redirect_valid", 32'(redirect_valid), 32'(m_rv));
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic ordy);
        in_valid      = v;
        in_op         = op;
        in_funct3     = f3;
        in_rd         = rd;
        in_pc         = pc;
        in_imm        = imm;
        opa           = a;
        opb           = b;
        in_eq         = (a == b);
        in_lu         = (a < b);
        in_ls         = ($signed(a) < $signed(b));
        in_alu_s      = (op == 3'd1) ? (a - b) : alu;
        in_store_data = sd;
        out_ready     = ordy;
    endtask

    // Architectural meaning of the beat currently on the inputs
    task automatic model_beat(output item_t it, output bit redir, output logic [31:0] tgt);
        bit tk = 1'b0;
        bit ill = 1'b0;
        bit mis;
        if (in_op == 3'd1) begin
            case (in_funct3)
                3'd0: tk = (opa == opb);
                3'd1: tk = (opa != opb);
                3'd4: tk = ($signed(opa) < $signed(opb));
                3'd5: tk = ($signed(opa) >= $signed(opb));
                3'd6: tk = (opa < opb);
                3'd7: tk = (opa >= opb);
                default: ill = 1'b1;
            endcase
        end
        tk  = tk || (in_op == 3'd2) || (in_op == 3'd3);
        tgt = (in_op == 3'd3) ? {in_alu_s[31:1], 1'b0} : in_pc + in_imm;
        mis = tk && (tgt % 4 != 0);
        it.op   = in_op;
        it.f3   = in_funct3;
        it.rd   = (in_op == 3'd1 || mis) ? 5'd0 : in_rd;
        it.res  = (in_op == 3'd2 || in_op == 3'd3) ? in_pc + 32'd4 :
                  (in_op == 3'd1) ? 32'd0 : in_alu_s;
        it.sd   = in_store_data;
        it.trap = ill || mis;
        redir   = tk && !mis;
    endtask

    task automatic cycle();
        bit          acc, drn, redir;
        item_t       it;
        logic [31:0] tgt;
        acc  = in_valid && (mq.size() < 2);
        drn  = (mq.size() > 0) && out_ready;
        if (drn) void'(mq.pop_front());
        m_rv = 1'b0;
        if (acc) begin
            if (m_kill) begin
                m_kill = 1'b0;
            end else begin
                model_beat(it, redir, tgt);
                mq.push_back(it);
                if (redir) begin
                    m_rv   = 1'b1;
                    m_rpc  = tgt;
                    m_kill = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy);
        drive(v, op, f3, rd, pc, imm, alu, a, b, 32'hA5A5_0000 | 32'(rd), ordy);
        cycle();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, ordy);
    endtask

    initial begin
        logic [2:0]  r_op, r_f3;
        logic [4:0]  r_rd;
        logic [31:0] r_pc, r_imm, r_alu, r_a, r_b;

        m_kill = 1'b0;
        m_rv   = 1'b0;
        m_rpc  = 32'd0;
        rst_n  = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_trap", 32'(out_trap), 32'd0);
        rst_n = 1'b1;
        check_outputs();

        // BEQ taken -> redirect 0x120, following ALU rd=5 dropped, next beat normal
        step(1'b1, 3'd1, 3'b000, 5'd9, 32'h100, 32'h20, 32'd0, 32'd5, 32'd5, 1'b1);
        chk("beq_redirect_pc", redirect_pc, 32'h120);
        step(1'b1, 3'd0, 3'd0, 5'd5, 32'h104, 32'd0, 32'h55, 32'd0, 32'd0, 1'b1);
        chk("beq_kill_drops", 32'(out_valid), 32'd0);
        step(1'b1, 3'd0, 3'd0, 5'd6, 32'h120, 32'd0, 32'h77, 32'd0, 32'd0, 1'b1);
        chk("beq_next_beat", out_result, 32'h77);

        // JALR -> redirect 0x304, link 0x204; kill the filler
        step(1'b1, 3'd3, 3'd0, 5'd1, 32'h200, 32'd0, 32'h305, 32'd0, 32'd0, 1'b1);
        chk("jalr_redirect_pc", redirect_pc, 32'h304);
        chk("jalr_result", out_result, 32'h204);
        step(1'b1, 3'd0, 3'd0, 5'd2, 32'h204, 32'd0, 32'h1, 32'd0, 32'd0, 1'b1);

        // BNE not taken, illegal funct3, misaligned JAL
        step(1'b1, 3'd1, 3'b001, 5'd7, 32'h300, 32'h40, 32'd0, 32'd3, 32'd3, 1'b1);
        chk("bne_no_redirect", 32'(redirect_valid), 32'd0);
        step(1'b1, 3'd1, 3'b010, 5'd7, 32'h304, 32'h40, 32'd0, 32'd3, 32'd3, 1'b1);
        chk("illegal_f3_trap", 32'(out_trap), 32'd1);
        step(1'b1, 3'd2, 3'd0, 5'd8, 32'h0, 32'h6, 32'd0, 32'd0, 32'd0, 1'b1);
        chk("jal_mis_trap", 32'(out_trap), 32'd1);
        chk("jal_mis_rd", 32'(out_rd), 32'd0);
        step(1'b1, 3'd0, 3'd0, 5'd9, 32'h4, 32'd0, 32'h99, 32'd0, 32'd0, 1'b1);
        chk("jal_mis_no_kill", out_result, 32'h99);

        // Backpressure: results 1,2,3 with a 3-cycle stall
        step(1'b1, 3'd0, 3'd0, 5'd1, 32'h10, 32'd0, 32'd1, 32'd0, 32'd0, 1'b0);
        step(1'b1, 3'd0, 3'd0, 5'd2, 32'h14, 32'd0, 32'd2, 32'd0, 32'd0, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, 3'd0, 3'd0, 5'd3, 32'h18, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
        step(1'b1, 3'd0, 3'd0, 5'd3, 32'h18, 32'd0, 32'd3, 32'd0, 32'd0, 1'b1);
        step(1'b1, 3'd0, 3'd0, 5'd3, 32'h18, 32'd0, 32'd3, 32'd0, 32'd0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Reset with both entries full and a redirect pending
        step(1'b1, 3'd0, 3'd0, 5'd4, 32'h40, 32'd0, 32'h44, 32'd0, 32'd0, 1'b0);
        step(1'b1, 3'd2, 3'd0, 5'd5, 32'h400, 32'h40, 32'd0, 32'd0, 32'd0, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_redirect", 32'(redirect_valid), 32'd1);
        drive(1'b0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        m_kill = 1'b0;
        m_rv   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd0, 3'd0, 5'd11, 32'h0, 32'd0, 32'hBEEF, 32'd0, 32'd0, 1'b1);
        chk("post_rst_not_dropped", out_result, 32'hBEEF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_f3  = 3'($urandom_range(0, 7));
            r_rd  = 5'($urandom_range(0, 31));
            r_pc  = $urandom & 32'hFFFF_FFFC;
            r_imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            r_alu = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            r_a   = $urandom;
            r_b   = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
            step(1'($urandom_range(0, 9) < 8), r_op, r_f3, r_rd, r_pc, r_imm, r_alu, r_a, r_b,
                 1'($urandom_range(0, 9) < 7));
        end
        repeat (3) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
